taps_mac: RTL and testbench

Time-multiplexed multiply-accumulate stage that sits directly downstream of the tapped memory shift register. On a start strobe it snapshots the full flat tap bus, then walks the taps with a single multiplier against a locally written coefficient bank and delivers one full-precision signed weighted sum per run. It turns the delay line's tap bus into a FIR/correlator output without instantiating COUNT multipliers.

---
 rtl/taps_mac.sv | 125 ++++++++++++
 tb/tb_taps_mac.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taps_mac.sv
// Time-multiplexed MAC: snapshots a flat tap bus on start, then walks the taps
// with one multiplier against a local coefficient bank, producing one signed sum per run.
module taps_mac #(
    parameter int WIDTH  = 16,
    parameter int COUNT  = 101,
    parameter int CWIDTH = 16,
    localparam int AWIDTH = (COUNT > 1) ? $clog2(COUNT) : 1,
    localparam int OWIDTH = WIDTH + CWIDTH + $clog2(COUNT)
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     coef_wren,
    input  logic [AWIDTH-1:0]        coef_addr,
    input  logic [CWIDTH-1:0]        coef_data,
    input  logic [COUNT*WIDTH-1:0]   taps,
    input  logic                     start,
    output logic                     busy,
    output logic signed [OWIDTH-1:0] res,
    output logic                     res_valid
);

    localparam int PWIDTH = WIDTH + CWIDTH;
    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(COUNT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;
    logic [AWIDTH-1:0]         idx_r;
    logic signed [OWIDTH-1:0]  acc_r;
    logic signed [OWIDTH-1:0]  acc_next_s;
    logic signed [PWIDTH-1:0]  prod_s;
    logic [WIDTH-1:0]          snap_r [COUNT];
    logic [CWIDTH-1:0]         coef_r [COUNT];
    logic                      accept_s;
    logic                      last_s;

    // Single shared multiplier; the sign-extending cast keeps the sum full precision.
    always_comb begin
        prod_s     = $signed(snap_r[idx_r]) * $signed(coef_r[idx_r]);
        acc_next_s = acc_r + OWIDTH'(prod_s);
    end

    // Next-state decode: start is only honoured from IDLE, so no run is ever queued.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = ACC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACC: begin
                if (idx_r == LAST_IDX) begin
                    last_s       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ACC;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: snapshot on accept, accumulate while running, publish on the last tap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r     <= '0;
            acc_r     <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < COUNT; i++) begin
                snap_r[i] <= '0;
            end
        end else begin
            res_valid <= last_s;
            busy      <= (state_next_s == ACC);
            if (accept_s) begin
                idx_r <= '0;
                acc_r <= '0;
                for (int i = 0; i < COUNT; i++) begin
                    snap_r[i] <= taps[i*WIDTH +: WIDTH];
                end
            end else if (state_r == ACC) begin
                acc_r <= acc_next_s;
                idx_r <= idx_r + AWIDTH'(1);
            end
            if (last_s) begin
                res <= acc_next_s;
            end
        end
    end

    // Coefficient bank; out-of-range addresses are dropped, writes allowed mid-run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < COUNT; i++) begin
                coef_r[i] <= '0;
            end
        end else if (coef_wren && (32'(coef_addr) < COUNT)) begin
            coef_r[coef_addr] <= coef_data;
        end
    end

endmodule

// File: tb/tb_taps_mac.sv
// Directed bench for taps_mac: COUNT=4 instance for the main scenarios, COUNT=5 instance
// so that an out-of-range coefficient address is actually representable.
module tb_taps_mac;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        coef_wren = 1'b0;
    logic [1:0]  coef_addr = 2'd0;
    logic [7:0]  coef_data = 8'd0;
    logic [31:0] taps = 32'd0;
    logic        start = 1'b0;
    logic        busy;
    logic signed [17:0] res;
    logic        res_valid;

    logic        coef_wren5 = 1'b0;
    logic [2:0]  coef_addr5 = 3'd0;
    logic [7:0]  coef_data5 = 8'd0;
    logic [39:0] taps5 = 40'd0;
    logic        start5 = 1'b0;
    logic        busy5;
    logic signed [18:0] res5;
    logic        res_valid5;

    int checks = 0;
    int failures = 0;

    taps_mac #(.WIDTH(8), .COUNT(4), .CWIDTH(8)) dut (
        .reset(reset), .clk(clk), .coef_wren(coef_wren), .coef_addr(coef_addr),
        .coef_data(coef_data), .taps(taps), .start(start), .busy(busy),
        .res(res), .res_valid(res_valid)
    );

    taps_mac #(.WIDTH(8), .COUNT(5), .CWIDTH(8)) dut5 (
        .reset(reset), .clk(clk), .coef_wren(coef_wren5), .coef_addr(coef_addr5),
        .coef_data(coef_data5), .taps(taps5), .start(start5), .busy(busy5),
        .res(res5), .res_valid(res_valid5)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
        coef_wren = 1'b1; coef_addr = a; coef_data = d;
        tick();
        coef_wren = 1'b0;
    endtask

    task automatic write_coef5(input logic [2:0] a, input logic [7:0] d);
        coef_wren5 = 1'b1; coef_addr5 = a; coef_data5 = d;
        tick();
        coef_wren5 = 1'b0;
    endtask

    task automatic load_coefs(input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
        write_coef(2'd0, c0); write_coef(2'd1, c1);
        write_coef(2'd2, c2); write_coef(2'd3, c3);
    endtask

    // Pulses start through edge E0; returns #1 after E0.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after E0 until res_valid; 0 means the bound expired.
    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (res_valid) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res !== 18'sd0) begin
            failures++;
            $display("FAIL reset_state busy=%b valid=%b res=%0d want 0/0/0", busy, res_valid, res);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        load_coefs(8'd1, 8'd2, 8'd3, 8'd4);
        taps = {8'd40, 8'd30, 8'd20, 8'd10};
        pulse_start();
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_e0 busy=%b valid=%b want 1/0", busy, res_valid);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (busy !== (k < 4) || res_valid !== (k == 4)) begin
                failures++;
                $display("FAIL basic_edge%0d busy=%b valid=%b want %b/%b",
                         k, busy, res_valid, (k < 4), (k == 4));
            end
        end
        checks++;
        if (res !== 18'sd300) begin
            failures++;
            $display("FAIL basic_res got %0d want 300", res);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || res !== 18'sd300 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold valid=%b res=%0d busy=%b want 0/300/0", res_valid, res, busy);
        end
    endtask

    task automatic test_signed();
        int n;
        load_coefs(8'h80, 8'h80, 8'h80, 8'h80);
        taps = {4{8'h80}};
        pulse_start();
        wait_valid(n);
        checks++;
        if (n != 4 || res !== 18'sd65536) begin
            failures++;
            $display("FAIL signed_neg_neg cycles=%0d res=%0d want 4/65536", n, res);
        end
        tick();
        load_coefs(8'd127, 8'd127, 8'd127, 8'd127);
        pulse_start();
        wait_valid(n);
        checks++;
        if (n != 4 || res !== -18'sd65024) begin
            failures++;
            $display("FAIL signed_pos_neg cycles=%0d res=%0d want 4/-65024", n, res);
        end
        tick();
    endtask

    task automatic test_snapshot();
        int n;
        load_coefs(8'd1, 8'd1, 8'd1, 8'd1);
        taps = {4{8'd1}};
        pulse_start();
        taps = {4{8'd5}};
        wait_valid(n);
        checks++;
        if (n != 4 || res !== 18'sd4) begin
            failures++;
            $display("FAIL snapshot cycles=%0d res=%0d want 4/4", n, res);
        end
        tick();
    endtask

    task automatic test_coef_timing();
        int n;
        load_coefs(8'd1, 8'd2, 8'd3, 8'd4);
        taps = {8'd40, 8'd30, 8'd20, 8'd10};
        pulse_start();
        // This write lands on E1, the same edge that consumes product 0.
        write_coef(2'd0, 8'd100);
        wait_valid(n);
        checks++;
        if (n != 3 || res !== 18'sd300) begin
            failures++;
            $display("FAIL coef_same_edge cycles=%0d res=%0d want 3/300", n, res);
        end
        tick();
        pulse_start();
        wait_valid(n);
        checks++;
        if (n != 4 || res !== 18'sd1290) begin
            failures++;
            $display("FAIL coef_next_run cycles=%0d res=%0d want 4/1290", n, res);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int hits;
        int pos [4];
        logic good_res;
        load_coefs(8'd1, 8'd2, 8'd3, 8'd4);
        taps = {8'd40, 8'd30, 8'd20, 8'd10};
        hits = 0;
        good_res = 1'b1;
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (res_valid) begin
                if (hits < 4) pos[hits] = c;
                hits++;
                if (res !== 18'sd300) good_res = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (hits != 4 || pos[0] != 4 || pos[1] != 9 || pos[2] != 14 || pos[3] != 19) begin
            failures++;
            $display("FAIL b2b_positions hits=%0d first=%0d second=%0d want 4 at 4,9,14,19",
                     hits, (hits > 0) ? pos[0] : -1, (hits > 1) ? pos[1] : -1);
        end
        checks++;
        if (!good_res) begin
            failures++;
            $display("FAIL b2b_res some result differs from 300 (last %0d)", res);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle busy=%b valid=%b want 0/0", busy, res_valid);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int spurious;
        pulse_start();
        tick(); tick();
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res !== 18'sd0) begin
            failures++;
            $display("FAIL reset_mid busy=%b valid=%b res=%0d want 0/0/0", busy, res_valid, res);
        end
        tick();
        reset = 1'b0;
        spurious = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (res_valid || busy) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL reset_no_result activity=%0d want 0", spurious);
        end
        pulse_start();
        wait_valid(n);
        checks++;
        if (n != 4 || res !== 18'sd0) begin
            failures++;
            $display("FAIL reset_coefs_cleared cycles=%0d res=%0d want 4/0", n, res);
        end
        tick();
    endtask

    task automatic test_oob_addr();
        int n;
        n = 0;
        for (int a = 0; a < 5; a++) write_coef5(3'(a), 8'd1);
        write_coef5(3'd5, 8'd9);
        write_coef5(3'd7, 8'd9);
        taps5 = {5{8'd1}};
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (res_valid5) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n != 5 || res5 !== 19'sd5) begin
            failures++;
            $display("FAIL oob_write cycles=%0d res=%0d want 5/5", n, res5);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_snapshot();
        test_coef_timing();
        test_back_to_back();
        test_reset_mid();
        test_oob_addr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
